// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential radix-2 shift-and-add unsigned multiplier. Each clock consumes
//   one multiplier bit. The start/valid handshake matches the restoring
//   divider, so both cores can be fed from the same operand registers.
//
// Parameters:
//   WIDTH         operand width; the product is 2*WIDTH bits
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         multiply request, sampled only when idle
//   multiplicand  operand A, captured on the accept edge
//   multiplier    operand B, captured on the accept edge
//   busy          high while an operation is in progress
//   valid         one-cycle pulse when product/ovf are updated
//   product       A*B, held until the next operation completes
//   ovf           upper half of product is non-zero
//
// Build option:
//   EARLY_TERM_EN finish as soon as the remaining multiplier bits are all zero
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MULT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CW-1:0]      r_cnt;
  // {carry, hi, lo}; lo starts as the multiplier and is shifted out LSB first
  logic [2*WIDTH:0]   r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_valid;
  logic [2*WIDTH-1:0] r_product;
  logic               r_ovf;

  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic               w_done;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_shift;
  logic [2*WIDTH-1:0] w_result;

`ifdef EARLY_TERM_EN
  logic [CW-1:0]      w_rem;
  logic [WIDTH-1:0]   w_mask;
`endif

  // Datapath: conditional add into the upper half, then shift right by one
  always_comb begin
    w_addend = r_acc[0] ? r_mcand : {WIDTH{1'b0}};
    // WIDTH+1-bit add keeps the carry, which lands in hi[MSB] after the shift
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_shift  = {1'b0, w_sum, r_acc[WIDTH-1:1]};
  end

`ifdef EARLY_TERM_EN
  // Finish once every not-yet-consumed multiplier bit (low w_rem bits of lo)
  // is zero; the skipped iterations would only shift, so apply that directly.
  always_comb begin
    w_rem    = CW'(WIDTH - 1) - r_cnt;
    w_mask   = ~({WIDTH{1'b1}} << w_rem);
    w_done   = ((w_shift[WIDTH-1:0] & w_mask) == {WIDTH{1'b0}});
    w_result = w_shift[2*WIDTH-1:0] >> w_rem;
  end
`else
  // Fixed-latency completion on the WIDTH-th iteration
  always_comb begin
    w_done   = (r_cnt == CW'(WIDTH - 1));
    w_result = w_shift[2*WIDTH-1:0];
  end
`endif

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_MULT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MULT: begin
        w_step = 1'b1;
        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_state_nxt = S_MULT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, accumulator, counter and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= {CW{1'b0}};
      r_acc     <= {(2*WIDTH+1){1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_valid   <= 1'b0;
      r_product <= {(2*WIDTH){1'b0}};
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_finish;
      if (w_load) begin
        r_mcand <= multiplicand;
        r_acc   <= {1'b0, {WIDTH{1'b0}}, multiplier};
        r_cnt   <= {CW{1'b0}};
      end else if (w_step) begin
        r_acc   <= w_shift;
        r_cnt   <= r_cnt + CW'(1);
      end else begin
        r_acc   <= r_acc;
        r_cnt   <= r_cnt;
      end
      if (w_finish) begin
        r_product <= w_result;
        r_ovf     <= |w_result[2*WIDTH-1:WIDTH];
      end else begin
        r_product <= r_product;
        r_ovf     <= r_ovf;
      end
    end
  end

  assign busy    = (r_state == S_MULT);
  assign valid   = r_valid;
  assign product = r_product;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Self-checking bench for shift_add_multiplier (WIDTH=16). Expected products
//   come from plain integer multiplication; expected latency comes from the
//   iteration-count rule (fixed 16, or highest set bit of B with EARLY_TERM_EN).
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        valid;
  logic [31:0] product;
  logic        ovf;

  int n_checks;
  int n_fail;

  shift_add_multiplier #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .busy         (busy),
    .valid        (valid),
    .product      (product),
    .ovf          (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Number of iterations the core needs for multiplier b
  function automatic int exp_lat(input logic [15:0] b);
`ifdef EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < 16; i++) if (b[i]) h = i + 1;
    return (h == 0) ? 1 : h;
`else
    return 16;
`endif
  endfunction

  // One operation: accept a*b, switch operands to a2/b2 after accept,
  // optionally spam start while busy, then check latency and result.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] a2, input logic [15:0] b2,
                       input bit poke, input string tag);
    logic [31:0] exp_p;
    int          lat;
    int          cyc;
    bit          seen;
    exp_p = 32'(a) * 32'(b);
    lat   = exp_lat(b);
    @(negedge clk);
    start = 1'b1; mcand = a; mplier = b;
    @(posedge clk); #1;
    start = 1'b0; mcand = a2; mplier = b2;
    check({tag, "_busy_acc"}, 64'(busy), 64'd1);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      if (poke) begin
        start = 1'b1; mcand = 16'($urandom); mplier = 16'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (valid) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
      end
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_product"}, 64'(product), 64'(exp_p));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_p[31:16] != 16'd0));
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, 64'(valid), 64'd0);
  endtask

  initial begin
    int          lat4;
    int          acc_e;
    int          exp_q[$];
    int          got_q[$];
    logic [15:0] ra;
    logic [15:0] rb;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; mcand = 16'd0; mplier = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, all-ones (carry every iteration), zero multiplier, sparse multiplier
    do_op(16'h0003, 16'h0005, 16'h0000, 16'h0000, 1'b0, "t1");
    do_op(16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, "t2");
    do_op(16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, "t3_zero");
    do_op(16'h1234, 16'h0100, 16'h0000, 16'h0000, 1'b0, "t3_b100");
    do_op(16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, "a_zero");

    // start held high for 40 edges: back-to-back accepts on each valid cycle
    lat4 = exp_lat(16'h0101);
    acc_e = 0;
    while (acc_e <= 39) begin
      exp_q.push_back(acc_e + lat4);
      acc_e = acc_e + lat4 + 1;
    end
    @(negedge clk);
    start = 1'b1; mcand = 16'h00FF; mplier = 16'h0101;
    for (int e = 0; e < 60; e++) begin
      @(posedge clk); #1;
      if (e == 39) start = 1'b0;
      if (valid) begin
        got_q.push_back(e);
        check("t4_product", 64'(product), 64'h0000FFFF);
      end
    end
    check("t4_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check("t4_valid_edge", 64'(got_q[i]), 64'(exp_q[i]));
      else check("t4_valid_missing", 64'(-1), 64'(exp_q[i]));
    end

    // Operands change right after accept
    do_op(16'h0002, 16'h0007, 16'hFFFF, 16'hFFFF, 1'b0, "t6");
    // start while busy must be ignored
    do_op(16'h00A5, 16'h0F0F, 16'h1111, 16'h2222, 1'b1, "poke");

    // Randomized operations against plain multiplication
    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 3) rb = rb & 16'h003F;
      do_op(ra, rb, 16'($urandom), 16'($urandom), k[0], "rand");
    end

    // Asynchronous reset mid-operation
    @(negedge clk);
    start = 1'b1; mcand = 16'h8000; mplier = 16'h8000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("t5_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_valid", 64'(valid), 64'd0);
    check("t5_rst_product", 64'(product), 64'd0);
    check("t5_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0, "t5_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
